// File: rtl/tlul_host_arb_2to1_if.sv
// TL-UL channel types and the host/device bundle for the 2:1 ICCM arbiter.
// master drives requests (h2d); slave returns responses (d2h).
package tlul_arb_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

interface tlul_host_arb_2to1_if;
    tlul_arb_pkg::tl_h2d_t h2d;
    tlul_arb_pkg::tl_d2h_t d2h;

    modport master (output h2d, input  d2h);
    modport slave  (input  h2d, output d2h);
endinterface

// File: rtl/tlul_host_arb_2to1.sv
// 2:1 TL-UL host arbiter for the ICCM port: round-robin A channel, in-order host-ID FIFO routes D.
// Optional per-host grant counters are enabled by defining TLUL_ARB_PERF_CNT_EN.
module tlul_host_arb_2to1
    import tlul_arb_pkg::*;
#(
    parameter  int unsigned MaxOutstanding = 2,
    localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    tlul_host_arb_2to1_if.slave         tl_h0,
    tlul_host_arb_2to1_if.slave         tl_h1,
    tlul_host_arb_2to1_if.master        tl_d,
    output logic [CntW-1:0]             outstanding_o,
    output logic                        err_unexp_o,
    output logic [31:0]                 grant_cnt0_o,
    output logic [31:0]                 grant_cnt1_o
);

    localparam int unsigned     PtrW   = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [PtrW-1:0] PtrMax = PtrW'(MaxOutstanding - 1);

    typedef enum logic { HostFetch = 1'b0, HostLsu = 1'b1 } host_e;

    host_e           sel, head;
    host_e           rr_q, rr_d, lock_host_q, lock_host_d;
    host_e           ids_q [MaxOutstanding];
    logic            lock_q, lock_d, err_q, err_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic            fifo_full, fifo_empty, push, pop;
    tl_h2d_t         dev_req;
    tl_d2h_t         h0_rsp, h1_rsp;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrMax) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full  = (cnt_q == CntW'(MaxOutstanding));
    assign fifo_empty = (cnt_q == '0);
    assign head       = ids_q[rptr_q];

    // A locked host keeps the device-side request stable until it is accepted.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        sel = HostFetch;
        if (lock_q) begin
            sel = lock_host_q;
        end else if (tl_h0.h2d.a_valid && tl_h1.h2d.a_valid) begin
            sel = rr_q;
        end else if (tl_h1.h2d.a_valid) begin
            sel = HostLsu;
        end
    end

    always_comb begin
        dev_req         = (sel == HostLsu) ? tl_h1.h2d : tl_h0.h2d;
        dev_req.a_valid = dev_req.a_valid & ~fifo_full;
        dev_req.d_ready = fifo_empty ? 1'b1
                        : ((head == HostLsu) ? tl_h1.h2d.d_ready : tl_h0.h2d.d_ready);

        h0_rsp          = tl_d.d2h;
        h0_rsp.a_ready  = ~fifo_full & (sel == HostFetch) & tl_d.d2h.a_ready;
        h0_rsp.d_valid  = ~fifo_empty & (head == HostFetch) & tl_d.d2h.d_valid;

        h1_rsp          = tl_d.d2h;
        h1_rsp.a_ready  = ~fifo_full & (sel == HostLsu) & tl_d.d2h.a_ready;
        h1_rsp.d_valid  = ~fifo_empty & (head == HostLsu) & tl_d.d2h.d_valid;
    end

    assign tl_d.h2d  = dev_req;
    assign tl_h0.d2h = h0_rsp;
    assign tl_h1.d2h = h1_rsp;

    // Full blocks the push even when a pop happens this cycle: no D-to-A path.
    assign push        = dev_req.a_valid & tl_d.d2h.a_ready;
    assign pop         = ~fifo_empty & tl_d.d2h.d_valid & dev_req.d_ready;

    assign cnt_d       = cnt_q + CntW'(push) - CntW'(pop);
    assign wptr_d      = push ? next_ptr(wptr_q) : wptr_q;
    assign rptr_d      = pop  ? next_ptr(rptr_q) : rptr_q;
    assign rr_d        = push ? host_e'(~sel) : rr_q;
    assign lock_d      = dev_req.a_valid & ~tl_d.d2h.a_ready;
    assign lock_host_d = sel;
    assign err_d       = err_q | (fifo_empty & tl_d.d2h.d_valid);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            rr_q        <= HostFetch;
            lock_q      <= 1'b0;
            lock_host_q <= HostFetch;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            rr_q        <= rr_d;
            lock_q      <= lock_d;
            lock_host_q <= lock_host_d;
            err_q       <= err_d;
        end
    end

    // NOTE: the ID storage is not reset; entries are only read while the count says they are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            ids_q[wptr_q] <= sel;
        end
    end

    assign outstanding_o = cnt_q;
    assign err_unexp_o   = err_q;

`ifdef TLUL_ARB_PERF_CNT_EN
    logic [31:0] gcnt0_q, gcnt1_q;

    // Saturating grant counters, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            if (push && (sel == HostFetch) && (gcnt0_q != 32'hFFFF_FFFF)) gcnt0_q <= gcnt0_q + 32'd1;
            if (push && (sel == HostLsu)   && (gcnt1_q != 32'hFFFF_FFFF)) gcnt1_q <= gcnt1_q + 32'd1;
        end
    end

    assign grant_cnt0_o = gcnt0_q;
    assign grant_cnt1_o = gcnt1_q;
`else
    assign grant_cnt0_o = 32'h0;
    assign grant_cnt1_o = 32'h0;
`endif

endmodule

// File: tb/tb_tlul_host_arb_2to1.sv
// Bench for tlul_host_arb_2to1: directed scenarios plus random traffic against a queue-based model.
module tb_tlul_host_arb_2to1;
    import tlul_arb_pkg::*;

    localparam int MAX = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  outstanding;
    logic        err_unexp;
    logic [31:0] gc0, gc1;

    always #5 clk = ~clk;

    tlul_host_arb_2to1_if h0_if ();
    tlul_host_arb_2to1_if h1_if ();
    tlul_host_arb_2to1_if d_if ();

    tlul_host_arb_2to1 #(.MaxOutstanding(MAX)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .tl_h0         (h0_if.slave),
        .tl_h1         (h1_if.slave),
        .tl_d          (d_if.master),
        .outstanding_o (outstanding),
        .err_unexp_o   (err_unexp),
        .grant_cnt0_o  (gc0),
        .grant_cnt1_o  (gc1)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] a_payload(input tl_h2d_t r);
        r.a_valid = 1'b0;
        r.d_ready = 1'b0;
        return 128'(r);
    endfunction

    function automatic logic [127:0] d_payload(input tl_d2h_t r);
        r.d_valid = 1'b0;
        r.a_ready = 1'b0;
        return 128'(r);
    endfunction

    // ---------------- reference model: in-order queue of host IDs ----------------
    int mq[$];
    int m_pref, m_lock_h, m_g0, m_g1;
    bit m_lock, m_err;

    always @(negedge clk) begin : compare
        tl_h2d_t r0, r1, dr;
        tl_d2h_t dd;
        int      sel, head;
        bit      full, exp_av, exp_dr, do_pop;
        if (!rst_n) begin
            mq.delete();
            m_pref = 0; m_lock = 0; m_lock_h = 0; m_err = 0; m_g0 = 0; m_g1 = 0;
            check("rst_outstanding", outstanding, 0);
            check("rst_err", err_unexp, 0);
            check("rst_gc0", gc0, 0);
            check("rst_gc1", gc1, 0);
        end else begin
            r0 = h0_if.h2d; r1 = h1_if.h2d; dr = d_if.h2d; dd = d_if.d2h;
            full = (mq.size() >= MAX);
            if (m_lock)                       sel = m_lock_h;
            else if (r0.a_valid && r1.a_valid) sel = m_pref;
            else                              sel = r1.a_valid ? 1 : 0;
            exp_av = !full && ((sel == 1) ? r1.a_valid : r0.a_valid);
            check("dev_a_valid", dr.a_valid, exp_av);
            if (exp_av) check("dev_a_fields", a_payload(dr), a_payload((sel == 1) ? r1 : r0));
            check("h0_a_ready", h0_if.d2h.a_ready, !full && sel == 0 && dd.a_ready);
            check("h1_a_ready", h1_if.d2h.a_ready, !full && sel == 1 && dd.a_ready);
            if (mq.size() > 0) begin
                head   = mq[0];
                exp_dr = (head == 1) ? r1.d_ready : r0.d_ready;
                check("dev_d_ready", dr.d_ready, exp_dr);
                check("h0_d_valid", h0_if.d2h.d_valid, head == 0 && dd.d_valid);
                check("h1_d_valid", h1_if.d2h.d_valid, head == 1 && dd.d_valid);
                if (dd.d_valid)
                    check("d_fields", d_payload((head == 1) ? h1_if.d2h : h0_if.d2h), d_payload(dd));
            end else begin
                exp_dr = 1'b1;
                check("dev_d_ready_drain", dr.d_ready, 1);
                check("h0_d_valid_idle", h0_if.d2h.d_valid, 0);
                check("h1_d_valid_idle", h1_if.d2h.d_valid, 0);
            end
            check("outstanding", outstanding, mq.size());
            check("err_unexp", err_unexp, m_err);
`ifdef TLUL_ARB_PERF_CNT_EN
            check("grant_cnt0", gc0, m_g0);
            check("grant_cnt1", gc1, m_g1);
`else
            check("grant_cnt0_off", gc0, 0);
            check("grant_cnt1_off", gc1, 0);
`endif
            // advance model to the state after the coming clock edge
            do_pop = (mq.size() > 0) && dd.d_valid && exp_dr;
            if (mq.size() == 0 && dd.d_valid) m_err = 1;
            if (do_pop) void'(mq.pop_front());
            if (exp_av && dd.a_ready) begin
                mq.push_back(sel);
                m_pref = 1 - sel;
                m_lock = 0;
                if (sel == 0) m_g0++; else m_g1++;
            end else begin
                m_lock   = exp_av;
                m_lock_h = sel;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic idle();
        h0_if.h2d = '0; h0_if.h2d.d_ready = 1'b1;
        h1_if.h2d = '0; h1_if.h2d.d_ready = 1'b1;
        d_if.d2h  = '0; d_if.d2h.a_ready  = 1'b1;
    endtask

    task automatic req(input int h, input bit v, input logic [31:0] addr);
        tl_h2d_t r;
        r = (h == 1) ? h1_if.h2d : h0_if.h2d;
        r.a_valid   = v;
        r.a_opcode  = 3'd4;
        r.a_address = addr;
        r.a_source  = 8'(h + 8'h10);
        r.a_mask    = 4'hF;
        r.a_data    = ~addr;
        if (h == 1) h1_if.h2d = r; else h0_if.h2d = r;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        neg();
        neg();
        step();
        rst_n = 1'b1;
    endtask

    task automatic beat(input bit v, input logic [31:0] data, input bit err);
        d_if.d2h.d_valid  = v;
        d_if.d2h.d_opcode = 3'd1;
        d_if.d2h.d_data   = data;
        d_if.d2h.d_error  = err;
    endtask

    task automatic rand_req(input int h);
        tl_h2d_t r;
        r           = (h == 1) ? h1_if.h2d : h0_if.h2d;
        r.a_valid   = ($urandom_range(0, 2) != 0);
        r.a_opcode  = 3'($urandom_range(0, 4));
        r.a_param   = 3'($urandom);
        r.a_size    = 2'($urandom);
        r.a_source  = 8'($urandom);
        r.a_address = $urandom;
        r.a_mask    = 4'($urandom);
        r.a_data    = $urandom;
        if (h == 1) h1_if.h2d = r; else h0_if.h2d = r;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        idle();
        do_reset();
        neg();
        check("reset_outstanding", outstanding, 2'd0);
        check("reset_err", err_unexp, 1'b0);
        step();

        // Contention: alternating grants, each response back to its originator
        do_reset(); idle();
        req(0, 1, 32'h100); req(1, 1, 32'h200);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) beat(1, 32'h50 + 32'(i), 0);
            if (i == 4) begin req(0, 0, 0); req(1, 0, 0); end
            neg();
            if (i < 4) check("cont_grant", {h1_if.d2h.a_ready, h0_if.d2h.a_ready}, (i % 2 == 1) ? 2'b10 : 2'b01);
            if (i > 0) check("cont_route", {h1_if.d2h.d_valid, h0_if.d2h.d_valid}, (i % 2 == 0) ? 2'b10 : 2'b01);
            step();
        end
        beat(0, 0, 0);
        neg();
`ifdef TLUL_ARB_PERF_CNT_EN
        check("cont_cnt0", gc0, 32'd2);
        check("cont_cnt1", gc1, 32'd2);
`else
        check("cont_cnt0_off", gc0, 32'd0);
        check("cont_cnt1_off", gc1, 32'd0);
`endif
        step();

        // Lock: h1 stalled by device, h0 has priority but must wait
        do_reset(); idle();
        d_if.d2h.a_ready = 1'b0;
        req(1, 1, 32'h300);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) req(0, 1, 32'h400);
            neg();
            check("lock_hold_addr", d_if.h2d.a_address, 32'h300);
            step();
        end
        d_if.d2h.a_ready = 1'b1;
        neg();
        check("lock_accept", {h1_if.d2h.a_ready, h0_if.d2h.a_ready, d_if.h2d.a_address}, {2'b10, 32'h300});
        step();
        req(1, 0, 0);
        neg();
        check("lock_next", {h1_if.d2h.a_ready, h0_if.d2h.a_ready, d_if.h2d.a_address}, {2'b01, 32'h400});
        step();
        req(0, 0, 0);

        // Full: third request blocks, pop cycle still blocks
        do_reset(); idle();
        req(0, 1, 32'h500);
        neg(); check("full_acc0", h0_if.d2h.a_ready, 1'b1); step();
        req(0, 1, 32'h504);
        neg(); check("full_acc1", h0_if.d2h.a_ready, 1'b1); step();
        req(0, 1, 32'h508);
        neg();
        check("full_blocked", {h0_if.d2h.a_ready, d_if.h2d.a_valid}, 2'b00);
        check("full_outstanding", outstanding, 2'd2);
        step();
        beat(1, 32'h77, 0);
        neg(); check("full_pop_blocks", {h0_if.d2h.a_ready, h0_if.d2h.d_valid}, 2'b01); step();
        beat(0, 0, 0);
        neg(); check("full_after_pop", {h0_if.d2h.a_ready, outstanding}, {1'b1, 2'd1}); step();
        req(0, 0, 0);

        // Ordering and error routing
        do_reset(); idle();
        req(0, 1, 32'h600);
        neg(); check("ord_h0_acc", h0_if.d2h.a_ready, 1'b1); step();
        req(0, 0, 0); req(1, 1, 32'h700);
        neg(); check("ord_h1_acc", h1_if.d2h.a_ready, 1'b1); step();
        req(1, 0, 0);
        beat(1, 32'hA, 1);
        neg();
        check("ord_beat_a", {h1_if.d2h.d_valid, h0_if.d2h.d_valid, h0_if.d2h.d_data, h0_if.d2h.d_error}, {2'b01, 32'hA, 1'b1});
        step();
        beat(1, 32'hB, 0);
        neg();
        check("ord_beat_b", {h1_if.d2h.d_valid, h0_if.d2h.d_valid, h1_if.d2h.d_data, h1_if.d2h.d_error}, {2'b10, 32'hB, 1'b0});
        step();
        beat(0, 0, 0);

        // Unexpected D, then mid-flight reset
        do_reset(); idle();
        beat(1, 32'hDEAD, 0);
        neg(); check("unexp_drain", {d_if.h2d.d_ready, err_unexp}, 2'b10); step();
        beat(0, 0, 0);
        neg(); check("unexp_sticky", err_unexp, 1'b1); step();
        req(0, 1, 32'h800);
        neg(); step();
        req(0, 0, 0);
        neg(); check("midrst_pre", outstanding, 2'd1); step();
        rst_n = 1'b0;
        #1;
        check("midrst_clear", {outstanding, err_unexp}, 3'b000);
        neg(); step();
        rst_n = 1'b1;
        beat(1, 32'hBEEF, 0);
        neg(); step();
        beat(0, 0, 0);
        neg(); check("postrst_unexp", err_unexp, 1'b1); step();

        // Five grants from h0 with a response every cycle
        do_reset(); idle();
        req(0, 1, 32'h900);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) beat(1, 32'(i), 0);
            if (i == 5) req(0, 0, 0);
            neg(); step();
        end
        beat(0, 0, 0);
        neg();
`ifdef TLUL_ARB_PERF_CNT_EN
        check("five_cnt0", gc0, 32'd5);
`else
        check("five_cnt0_off", gc0, 32'd0);
`endif
        step();

        // Random traffic; the device answers only what it has accepted
        do_reset(); idle();
        begin
            int pend = 0;
            bit f0, f1, ahs, dhs;
            for (int n = 0; n < 3000; n++) begin
                neg();
                f0  = h0_if.h2d.a_valid && h0_if.d2h.a_ready;
                f1  = h1_if.h2d.a_valid && h1_if.d2h.a_ready;
                ahs = d_if.h2d.a_valid && d_if.d2h.a_ready;
                dhs = d_if.d2h.d_valid && d_if.h2d.d_ready;
                step();
                pend = pend + int'(ahs) - int'(dhs);
                if (!h0_if.h2d.a_valid || f0) rand_req(0);
                if (!h1_if.h2d.a_valid || f1) rand_req(1);
                h0_if.h2d.d_ready = ($urandom_range(0, 3) != 0);
                h1_if.h2d.d_ready = ($urandom_range(0, 3) != 0);
                d_if.d2h.a_ready  = ($urandom_range(0, 3) != 0);
                if (!(d_if.d2h.d_valid && !dhs)) begin
                    d_if.d2h.d_valid  = (pend > 0) && ($urandom_range(0, 2) != 0);
                    d_if.d2h.d_opcode = 3'($urandom);
                    d_if.d2h.d_param  = 3'($urandom);
                    d_if.d2h.d_size   = 2'($urandom);
                    d_if.d2h.d_source = 8'($urandom);
                    d_if.d2h.d_sink   = 1'($urandom);
                    d_if.d2h.d_data   = $urandom;
                    d_if.d2h.d_error  = 1'($urandom);
                end
            end
        end
        idle();
        neg(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
